// File: rtl/arm_data_mem_responder.sv
// ---------------------------------------------------------------------------
// arm_data_mem_responder
//
// Responder side of the MEM-stage data-memory port of the ARM pipeline.
// Load/store requests are captured in IDLE, held for WAIT_CYCLES wait states,
// then completed in a single DONE cycle with a one-cycle ready pulse. The
// pipeline is frozen for as long as a request is outstanding.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit RAM words (power of two, >= 2)
//   BASE_ADDR    byte address of word 0
//   WAIT_CYCLES  wait states before completion (0 is legal)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   mem_r_en  in   load request, held until ready
//   mem_w_en  in   store request, held until ready
//   addr      in   byte address, held with the request
//   wdata     in   store data, held with the request
//   rdata     out  load result, valid in the ready cycle and held afterwards
//   ready     out  one-cycle completion pulse
//   err       out  completed request was illegal (only with ready)
//   freeze    out  combinational stall request to the pipeline
// ---------------------------------------------------------------------------
module arm_data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        freeze
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;
    // One past the last legal byte address, in 33 bits so a RAM ending at
    // the top of the 32-bit space cannot wrap to a small value.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_wdata;
    logic              r_is_load;
    logic              r_is_store;
    logic              r_illegal;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_req;
    logic              w_in_idle;
    logic              w_illegal;
    logic [IDX_W-1:0]  w_idx;
    logic              w_enter_done;
    logic              w_fin_illegal;
    logic              w_fin_load;
    logic [IDX_W-1:0]  w_fin_idx;
    logic              w_store_commit;

    assign w_req     = mem_r_en | mem_w_en;
    assign w_in_idle = (r_state == ST_IDLE);

    // Index is only meaningful once the range check has passed.
    assign w_idx     = IDX_W'((addr - BASE_ADDR) >> 2);
    assign w_illegal = (addr[1:0] != 2'b00)
                     | (addr < BASE_ADDR)
                     | ({1'b0, addr} >= END_ADDR)
                     | (mem_r_en & mem_w_en);

    // With zero wait states the request goes IDLE -> DONE on the sampling
    // edge, so the completion values come straight from the inputs rather
    // than from the copies being latched on that same edge.
    assign w_enter_done = (w_in_idle & w_req & (WAIT_CYCLES == 0))
                        | ((r_state == ST_WAIT) & (r_wcnt == '0));
    assign w_fin_illegal = w_in_idle ? w_illegal : r_illegal;
    assign w_fin_load    = w_in_idle ? mem_r_en  : r_is_load;
    assign w_fin_idx     = w_in_idle ? w_idx     : r_idx;

    assign w_store_commit = (r_state == ST_DONE) & r_is_store & ~r_illegal;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_illegal  <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx      <= w_idx;
                        r_wdata    <= wdata;
                        r_is_load  <= mem_r_en;
                        r_is_store <= mem_w_en;
                        r_illegal  <= w_illegal;
                        if (w_enter_done) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_wcnt  <= WCNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_enter_done) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Completion outputs are registered on the edge entering DONE so
            // they are valid for the whole DONE cycle.
            if (w_enter_done) begin
                r_ready <= 1'b1;
                r_err   <= w_fin_illegal;
                if (w_fin_load) begin
                    r_rdata <= w_fin_illegal ? 32'd0 : r_mem[w_fin_idx];
                end
            end
        end
    end

    // NOTE: the RAM array has no reset; its contents are undefined until
    // written, which keeps it mappable onto plain memory macros.
    always_ff @(posedge clk) begin
        if (w_store_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign rdata  = r_rdata;
    assign ready  = r_ready;
    assign err    = r_err;
    assign freeze = (w_in_idle & w_req) | (r_state == ST_WAIT);

endmodule

// File: tb/tb_arm_data_mem_responder.sv
// ---------------------------------------------------------------------------
// Bench for arm_data_mem_responder: one instance with two wait states and
// one with zero wait states. Directed vectors from a table, a randomized
// phase checked against a word-array memory model, and hand-written
// sequences for back-to-back access and reset during a store.
// ---------------------------------------------------------------------------
module tb_arm_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with WAIT_CYCLES = 2
    logic        a_rst_n, a_r, a_w;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ready, a_err, a_freeze;

    // Instance with WAIT_CYCLES = 0
    logic        z_rst_n, z_r, z_w;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_ready, z_err, z_freeze;

    arm_data_mem_responder #(
        .DEPTH_WORDS(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(2)
    ) u_dut_a (
        .clk(clk), .reset(a_rst_n), .mem_r_en(a_r), .mem_w_en(a_w),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .ready(a_ready), .err(a_err), .freeze(a_freeze)
    );

    arm_data_mem_responder #(
        .DEPTH_WORDS(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)
    ) u_dut_z (
        .clk(clk), .reset(z_rst_n), .mem_r_en(z_r), .mem_w_en(z_w),
        .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata),
        .ready(z_ready), .err(z_err), .freeze(z_freeze)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model for the WAIT_CYCLES=2 instance -------
    logic [31:0] m_mem   [64];
    bit          m_known [64];
    logic [31:0] m_rd;
    bit          m_rd_known;

    task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, output logic e_err,
                              output logic [31:0] e_rd, output bit e_rd_valid);
        longint ua;
        bit     bad;
        int     idx;
        ua  = longint'(a);
        bad = (ua % 4 != 0) || (ua < 1024) || (ua >= 1024 + 4 * 64) || (r && w);
        idx = int'((ua - 1024) / 4);
        e_err = bad;
        if (r && w) begin
            m_rd_known = 1'b0;
        end else if (r) begin
            if (bad) begin
                m_rd       = 32'd0;
                m_rd_known = 1'b1;
            end else begin
                m_rd       = m_mem[idx];
                m_rd_known = m_known[idx];
            end
        end else if (w && !bad) begin
            m_mem[idx]   = d;
            m_known[idx] = 1'b1;
        end
        e_rd       = m_rd;
        e_rd_valid = m_rd_known;
    endtask

    // Drives one request on the chosen instance (entered at a negedge with the
    // instance idle), waits for ready, counts freeze cycles and drops the
    // request. Returns lat = -1 if ready never came.
    task automatic run_access(input bit on_z, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic e,
                              output int lat, output int fz);
        logic rdy, frz;
        rd  = 'x;
        e   = 1'bx;
        lat = -1;
        fz  = 0;
        if (on_z) begin
            z_r = r; z_w = w; z_addr = a; z_wdata = d;
        end else begin
            a_r = r; a_w = w; a_addr = a; a_wdata = d;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            rdy = on_z ? z_ready : a_ready;
            frz = on_z ? z_freeze : a_freeze;
            if (frz) fz++;
            if (rdy) begin
                lat = k;
                rd  = on_z ? z_rdata : a_rdata;
                e   = on_z ? z_err : a_err;
                break;
            end
            @(negedge clk);
        end
        if (on_z) begin
            z_r = 1'b0; z_w = 1'b0;
        end else begin
            a_r = 1'b0; a_w = 1'b0;
        end
        @(negedge clk);
        #1;
        check(on_z ? "z_ready_pulse" : "a_ready_pulse",
              32'(on_z ? z_ready : a_ready), 32'd0);
    endtask

    task automatic a_access(input string name, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd, e_rd;
        logic        e, e_err;
        bit          e_rd_valid;
        int          lat, fz;
        run_access(1'b0, r, w, a, d, rd, e, lat, fz);
        model_step(r, w, a, d, e_err, e_rd, e_rd_valid);
        check($sformatf("%s_err", name), 32'(e), 32'(e_err));
        if (e_rd_valid) check($sformatf("%s_rdata", name), rd, e_rd);
        check($sformatf("%s_latency", name), 32'(lat), 32'd3);
        check($sformatf("%s_freeze", name), 32'(fz), 32'd3);
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        bit          cmp_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] rd, e_rd, ta, td;
        logic        e, e_err;
        bit          e_rd_valid;
        int          lat, fz, kind, wi, op, prev, got;

        tbl[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'd1276, 32'h12345678, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[4]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'd1280, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'd1026, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'd1280, 32'hAAAAAAAA, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 1'b0, 32'd1276, 32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[11] = '{1'b1, 1'b1, 32'd1024, 32'h55555555, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};

        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        m_rd       = 32'd0;
        m_rd_known = 1'b1;

        a_rst_n = 1'b0; a_r = 1'b0; a_w = 1'b0; a_addr = '0; a_wdata = '0;
        z_rst_n = 1'b0; z_r = 1'b0; z_w = 1'b0; z_addr = '0; z_wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("a_reset_ready",  32'(a_ready),  32'd0);
        check("a_reset_err",    32'(a_err),    32'd0);
        check("a_reset_rdata",  a_rdata,       32'd0);
        check("a_reset_freeze", 32'(a_freeze), 32'd0);
        check("z_reset_ready",  32'(z_ready),  32'd0);
        check("z_reset_rdata",  z_rdata,       32'd0);
        a_rst_n = 1'b1;
        z_rst_n = 1'b1;
        @(negedge clk);
        #1;

        // ---------------- directed table (WAIT_CYCLES=2) ----------------
        for (int i = 0; i < 13; i++) begin
            run_access(1'b0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, rd, e, lat, fz);
            model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, e_err, e_rd, e_rd_valid);
            check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            if (tbl[i].cmp_rd)  check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            else if (e_rd_valid) check($sformatf("tbl%0d_rdata_held", i), rd, e_rd);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("tbl%0d_freeze", i), 32'(fz), 32'd3);
        end

        // ---------------- randomized accesses against the model ----------------
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            wi   = int'($urandom_range(0, 63));
            case (kind)
                0:       ta = 32'(1024 + 4 * wi + int'($urandom_range(1, 3)));
                1:       ta = 32'(1024 - 4 * int'($urandom_range(1, 8)));
                2:       ta = 32'(1280 + 4 * int'($urandom_range(0, 8)));
                default: ta = 32'(1024 + 4 * wi);
            endcase
            td = $urandom;
            op = int'($urandom_range(0, 5));
            if (op == 0)      a_access($sformatf("rnd%0d", i), 1'b1, 1'b1, ta, td);
            else if (op <= 2) a_access($sformatf("rnd%0d", i), 1'b1, 1'b0, ta, td);
            else              a_access($sformatf("rnd%0d", i), 1'b0, 1'b1, ta, td);
        end

        // ---------------- zero wait states ----------------
        for (int i = 0; i < 4; i++) begin
            run_access(1'b1, 1'b0, 1'b1, 32'(1024 + 4 * i), 32'hA0000000 + 32'(i), rd, e, lat, fz);
            check($sformatf("z_store%0d_err", i), 32'(e), 32'd0);
            check($sformatf("z_store%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("z_store%0d_freeze", i), 32'(fz), 32'd1);
        end
        run_access(1'b1, 1'b1, 1'b0, 32'd1280, 32'h0, rd, e, lat, fz);
        check("z_illegal_err",     32'(e),   32'd1);
        check("z_illegal_rdata",   rd,       32'd0);
        check("z_illegal_latency", 32'(lat), 32'd1);

        // Back-to-back loads with the request held: one ready every 2 cycles.
        z_r    = 1'b1;
        z_addr = 32'd1024;
        prev   = -1;
        got    = 0;
        for (int k = 0; k < 16 && got < 4; k++) begin
            #1;
            if (z_ready) begin
                check($sformatf("b2b%0d_rdata", got), z_rdata, 32'hA0000000 + 32'(got));
                check($sformatf("b2b%0d_err", got), 32'(z_err), 32'd0);
                if (got > 0) check($sformatf("b2b%0d_spacing", got), 32'(k - prev), 32'd2);
                prev = k;
                got++;
                if (got < 4) z_addr = 32'(1024 + 4 * got);
                else         z_r = 1'b0;
            end
            @(negedge clk);
        end
        z_r = 1'b0;
        check("b2b_count", 32'(got), 32'd4);
        @(negedge clk);
        #1;

        // ---------------- reset during a store (WAIT_CYCLES=2) ----------------
        a_access("rst_pre_store", 1'b0, 1'b1, 32'd1032, 32'h11111111);
        a_access("rst_pre_load",  1'b1, 1'b0, 32'd1032, 32'h0);
        a_w     = 1'b1;
        a_addr  = 32'd1032;
        a_wdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        check("rst_freeze_in_wait", 32'(a_freeze), 32'd1);
        a_rst_n = 1'b0;
        a_w     = 1'b0;
        #1;
        check("rst_now_ready",  32'(a_ready),  32'd0);
        check("rst_now_err",    32'(a_err),    32'd0);
        check("rst_now_rdata",  a_rdata,       32'd0);
        check("rst_now_freeze", 32'(a_freeze), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_hold_ready", 32'(a_ready), 32'd0);
        end
        a_rst_n    = 1'b1;
        m_rd       = 32'd0;
        m_rd_known = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("rst_after_ready", 32'(a_ready), 32'd0);
        end
        a_access("rst_reload", 1'b1, 1'b0, 32'd1032, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/arm_data_mem_responder.md
# arm_data_mem_responder

Responder end of the MEM-stage data-memory interface of the ARM pipeline. It accepts load/store requests (`mem_r_en` / `mem_w_en`, address from the EXE ALU result, store data from `val_rm`) and serves them from an internal word-addressed RAM after a configurable number of wait states. While a request is outstanding it drives `freeze` back to the pipeline. It completes each request with a one-cycle `ready` pulse.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit RAM words; power of two, ≥ 2.
- `BASE_ADDR`, default 32'd1024: byte address of word 0.
- `WAIT_CYCLES`, default 2: wait states inserted before completion; 0 is legal.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: reset. It is asynchronous and active-low, so `reset`=0 resets the block immediately.
- `mem_r_en`  in  1: load request; held by the requester until `ready`.
- `mem_w_en`  in  1: store request; held by the requester until `ready`.
- `addr`  in  32: byte address (`exe_alu_res_out`); held with the request.
- `wdata`  in  32: store data (`exe_val_rm_out`); held with the request.
- `rdata`  out  32: load result; valid in the `ready` cycle and held afterwards.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: asserted together with `ready` when the completed request was illegal.
- `freeze`  out  1: combinational stall request to the pipeline.

## Operation
- The state machine has three states: IDLE, WAIT and DONE. A wait counter `wcnt` of width max(1, $clog2(WAIT_CYCLES+1)) runs alongside it.
- **IDLE:**
  - A request exists when `req` = `mem_r_en | mem_w_en`.
  - On `req`, the block latches `addr`, `wdata` and the operation, and computes legality.
  - It then moves to WAIT with `wcnt`=WAIT_CYCLES-1, or straight to DONE if WAIT_CYCLES=0.
- **WAIT:**
  - `wcnt` decrements by 1 each cycle.
  - When `wcnt`=0, the block moves to DONE.
  - Input changes during WAIT are ignored because the latched copies are used.
- **DONE** (one cycle):
  - `ready`=1.
  - A legal store writes `mem[idx]` <= latched wdata at the end of this cycle.
  - A legal load drives `rdata` = `mem[idx]`.
  - The next state is always IDLE.
- Word index: `idx` = (latched addr − BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits after the range check.
- A request is illegal if any of these hold:
  - `addr[1:0]` ≠ 0.
  - `addr` < BASE_ADDR.
  - `addr` ≥ BASE_ADDR + 4·DEPTH_WORDS. This comparison is done in 33-bit unsigned arithmetic so it cannot wrap.
  - `mem_r_en` and `mem_w_en` are both 1.
- An illegal request still takes the full latency. In DONE it gives `err`=1, `rdata`=0, and leaves memory unchanged.
- `freeze` = (state==IDLE & `req`) | (state==WAIT). It is 0 in DONE, so the pipeline advances on the `ready` edge.
- Back-to-back requests:
  - A `req` seen in IDLE the cycle after DONE is treated as a new request, because the pipeline has advanced.
  - The minimum spacing is therefore WAIT_CYCLES+2 cycles per access.
- `rdata` updates only in the DONE cycle of a load, legal or illegal. Stores leave it unchanged.

## Timing
- Reset values:
  - state=IDLE, `wcnt`=0, `rdata`=0, `ready`=0, `err`=0.
  - `freeze` follows its combinational equation (0 unless `req`=1).
  - RAM contents are not reset and are undefined until written.
- Latency: the request is sampled at edge N; `ready` is high during cycle N+WAIT_CYCLES+1.
  - With WAIT_CYCLES=0, `ready` is high in the cycle after the sampling edge.
- `ready`, `err` and `rdata` are registered. `freeze` is combinational from `req` and state.
- Reset asserted mid-transaction:
  - The block returns to IDLE immediately and the pending store is dropped.
  - No `ready` is issued.
  - After reset deasserts, a still-held request restarts from IDLE.
- A request deasserted by the requester before `ready` is a protocol violation. The block completes the latched request anyway.

## Test plan
- **Reset, then store and load:** with WAIT_CYCLES=2, store `wdata`=32'hDEADBEEF to `addr`=1024. Expect `freeze`=1 for 3 cycles and `ready` in the 3rd cycle after sampling. A following load from 1024 returns 32'hDEADBEEF with `err`=0.
- **Top word:** a store then load at `addr`=1024+4·63=1276 round-trips 32'h12345678. Word 0 must still hold 32'hDEADBEEF.
- **Illegal addresses:** a load from 1020, 1280 and 1026 each give `ready`=1, `err`=1, `rdata`=0. A store to 1280 leaves all words unchanged, checked by reading back word 0 and word 63.
- **Simultaneous enables:** `mem_r_en`=`mem_w_en`=1 at 1024 gives `err`=1, and word 0 is unchanged.
- **Zero wait states:** with WAIT_CYCLES=0, `ready` appears one cycle after sampling and `freeze` is high for exactly 1 cycle. Back-to-back loads complete every 2 cycles.
- **Reset during a store:** assert `reset`=0 during WAIT of a store of 32'hCAFEF00D to 1032. Expect outputs at reset values immediately and no `ready`. A reload after reset, with a prior known value at 1032, shows the old value.
